// File: rtl/psum_accum_buffer_pkg.sv
// Shared sizing constants and controller state encoding for the
// partial-sum accumulation buffer behind the systolic array.
package psum_accum_buffer_pkg;

   localparam int ARRAY_COL      = 16;   // lanes per psum vector
   localparam int ACC_WIDTH      = 32;   // signed psum / accumulator width
   localparam int PSUM_BUF_DEPTH = 64;   // maximum rows per tile

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/psum_accum_buffer_deskew.sv
// Deskew stage: realigns the staggered bottom-row psums so every lane of a
// row appears in the same cycle. Lane c arrives c cycles after column 0, so
// it is delayed by ARRAY_COL-1-c; the row control bits ride a full-depth
// delay line. The flush input drops every in-flight row (used while the
// buffer is draining and cannot accept writes).
module psum_accum_buffer_deskew
   import psum_accum_buffer_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [ARRAY_COL*ACC_WIDTH-1:0] in_psum_vec,
   input  logic                           in_valid,
   input  logic                           in_tile_first,
   input  logic                           in_tile_last,
   output logic [ARRAY_COL*ACC_WIDTH-1:0] a_vec,
   output logic                           a_valid,
   output logic                           a_first,
   output logic                           a_last
);

   localparam int CD = ARRAY_COL - 1;

   logic [CD-1:0] vld_sr;
   logic [CD-1:0] first_sr;
   logic [CD-1:0] last_sr;

   for (genvar c = 0; c < ARRAY_COL; c++) begin : g_lane
      localparam int DLY = ARRAY_COL - 1 - c;
      if (DLY == 0) begin : g_pass
         assign a_vec[c*ACC_WIDTH +: ACC_WIDTH] = in_psum_vec[c*ACC_WIDTH +: ACC_WIDTH];
      end else begin : g_dly
         logic [ACC_WIDTH-1:0] sr [DLY];
         // shift this lane's data one stage per cycle (data path, no reset)
         always_ff @(posedge clk) begin
            sr[0] <= in_psum_vec[c*ACC_WIDTH +: ACC_WIDTH];
            for (int i = 1; i < DLY; i++) begin
               sr[i] <= sr[i-1];
            end
         end
         assign a_vec[c*ACC_WIDTH +: ACC_WIDTH] = sr[DLY-1];
      end
   end

   // row-valid delay line; cleared by reset and by flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_sr <= '0;
      end else if (flush) begin
         vld_sr <= '0;
      end else begin
         vld_sr <= {vld_sr[CD-2:0], in_valid};
      end
   end

   // first/last qualifiers only matter alongside valid, so they carry no reset
   always_ff @(posedge clk) begin
      first_sr <= {first_sr[CD-2:0], in_tile_first};
      last_sr  <= {last_sr[CD-2:0], in_tile_last};
   end

   assign a_valid = vld_sr[CD-1];
   assign a_first = first_sr[CD-1];
   assign a_last  = last_sr[CD-1];

endmodule

// File: rtl/psum_accum_buffer.sv
// Output stage behind the systolic array: deskews the psum rows, accumulates
// them across K-tiles with signed saturation, then drains finished rows over
// a valid/ready handshake. New passes are refused only while draining.
module psum_accum_buffer
   import psum_accum_buffer_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ARRAY_COL*ACC_WIDTH-1:0] in_psum_vec,
   input  logic                           in_valid,
   input  logic                           in_tile_first,
   input  logic                           in_tile_last,
   input  logic [6:0]                     cfg_rows,
   output logic                           in_ready,
   output logic [ARRAY_COL*ACC_WIDTH-1:0] out_vec,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           done,
   output logic                           err_ovf,
   output logic                           err_overrun
);

   localparam int VEC_W = ARRAY_COL * ACC_WIDTH;
   localparam int PTR_W = $clog2(PSUM_BUF_DEPTH);

   // clamp a one-bit-wider sum back into the accumulator range
   function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [ACC_WIDTH:0] sum);
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
         return sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
      return sum[ACC_WIDTH-1:0];
   endfunction

   function automatic logic sat_hit(input logic signed [ACC_WIDTH:0] sum);
      return sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
   endfunction

   // a cfg_rows of 0 selects the full buffer depth
   function automatic logic [6:0] rows_of(input logic [6:0] cfg);
      return (cfg == 7'd0) ? 7'(PSUM_BUF_DEPTH) : cfg;
   endfunction

   state_t                   state, state_nxt;
   logic [VEC_W-1:0]         a_vec;
   logic                     a_valid, a_first, a_last;
   logic [PTR_W-1:0]         wr_ptr, rd_ptr, rd_idx, last_row;
   logic [6:0]               rows_q, rows_cur;
   logic                     wr_en, wr_last, xfer, rd_last, ovf_any;
   logic [VEC_W-1:0]         old_row, wr_row;
   logic signed [ACC_WIDTH-1:0] old_l, new_l;
   logic signed [ACC_WIDTH:0]   sum_l;
   logic [VEC_W-1:0]         psum_buf [PSUM_BUF_DEPTH];

   psum_accum_buffer_deskew u_deskew (
      .clk           (clk),
      .rst           (rst),
      .flush         (state == DRAIN),
      .in_psum_vec   (in_psum_vec),
      .in_valid      (in_valid),
      .in_tile_first (in_tile_first),
      .in_tile_last  (in_tile_last),
      .a_vec         (a_vec),
      .a_valid       (a_valid),
      .a_first       (a_first),
      .a_last        (a_last)
   );

   // In IDLE the live cfg_rows governs the very first row; afterwards the latched copy.
   assign rows_cur = (state == IDLE) ? rows_of(cfg_rows) : rows_q;
   assign last_row = PTR_W'(rows_cur - 7'd1);
   assign wr_en    = a_valid && (state != DRAIN);
   assign wr_last  = wr_en && a_last && (wr_ptr == last_row);
   assign xfer     = out_valid && out_ready;
   assign rd_last  = (rd_ptr == last_row);
   assign rd_idx   = xfer ? rd_ptr + 1'b1 : rd_ptr;

   // per-lane read-modify-write: overwrite on first tile, saturating add otherwise
   always_comb begin
      old_row = psum_buf[wr_ptr];
      wr_row  = a_vec;
      ovf_any = 1'b0;
      old_l   = '0;
      new_l   = '0;
      sum_l   = '0;
      for (int c = 0; c < ARRAY_COL; c++) begin
         old_l = old_row[c*ACC_WIDTH +: ACC_WIDTH];
         new_l = a_vec[c*ACC_WIDTH +: ACC_WIDTH];
         sum_l = {old_l[ACC_WIDTH-1], old_l} + {new_l[ACC_WIDTH-1], new_l};
         if (!a_first) begin
            wr_row[c*ACC_WIDTH +: ACC_WIDTH] = sat(sum_l);
            ovf_any = ovf_any | sat_hit(sum_l);
         end
      end
   end

   // controller state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state, ready and completion pulse
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (wr_last)    state_nxt = DRAIN;
            else if (wr_en) state_nxt = ACCUM;
         end
         ACCUM: begin
            if (wr_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            in_ready = 1'b0;
            if (xfer && rd_last) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // pointers, row-count latch, output valid and sticky error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rows_q      <= 7'(PSUM_BUF_DEPTH);
         out_valid   <= 1'b0;
         err_ovf     <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         if (state == IDLE && wr_en) rows_q <= rows_cur;
         if (wr_en) wr_ptr <= (wr_ptr == last_row) ? '0 : wr_ptr + 1'b1;
         if (wr_en && ovf_any) err_ovf <= 1'b1;
         if (in_valid && state == DRAIN) err_overrun <= 1'b1;
         if (state == DRAIN) begin
            if (!out_valid) begin
               out_valid <= 1'b1;
            end else if (xfer) begin
               if (rd_last) begin
                  out_valid <= 1'b0;
                  rd_ptr    <= '0;
               end else begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
            end
         end
      end
   end

   // accumulator storage write (contents survive reset)
   always_ff @(posedge clk) begin
      if (wr_en) psum_buf[wr_ptr] <= wr_row;
   end

   // output register: load the next row when empty or when the current one is taken
   always_ff @(posedge clk) begin
      if (state == DRAIN && (!out_valid || xfer)) out_vec <= psum_buf[rd_idx];
   end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Bench for psum_accum_buffer: skewed row driver, tile-level accumulation
// model with saturation, and a per-cycle output checker.
module tb_psum_accum_buffer;

   localparam int NC = 16;
   localparam int W  = 32;
   localparam int VW = NC * W;
   typedef logic [VW-1:0] vec_t;

   logic          clk = 1'b0;
   logic          rst;
   vec_t          in_psum_vec;
   logic          in_valid, in_tile_first, in_tile_last;
   logic [6:0]    cfg_rows;
   logic          in_ready;
   vec_t          out_vec;
   logic          out_valid, out_ready, done, err_ovf, err_overrun;

   always #5 clk = ~clk;

   psum_accum_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .in_psum_vec   (in_psum_vec),
      .in_valid      (in_valid),
      .in_tile_first (in_tile_first),
      .in_tile_last  (in_tile_last),
      .cfg_rows      (cfg_rows),
      .in_ready      (in_ready),
      .out_vec       (out_vec),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .done          (done),
      .err_ovf       (err_ovf),
      .err_overrun   (err_overrun)
   );

   int   cmps = 0;
   int   errs = 0;
   vec_t exp_q[$];
   vec_t got_log[$];
   int   drains = 0;
   int   xfers = 0;
   int   xfer_base = 0;
   int   mbuf [64][NC];
   bit   model_ovf = 1'b0;
   vec_t hist_d [NC];
   bit   hist_v [NC];
   int   ready_mode = 0;
   int   pat = 0;
   vec_t prev_vec;
   bit   prev_hold = 1'b0;
   vec_t cmp_e;

   task automatic checkv(input string name, input vec_t got, input vec_t expv);
      cmps++;
      if (got !== expv) begin
         errs++;
         $display("FAIL %s: got %h required %h", name, got, expv);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] expv);
      cmps++;
      if (got !== expv) begin
         errs++;
         $display("FAIL %s: got %h required %h", name, got, expv);
      end
   endtask

   task automatic check1(input string name, input logic got, input logic expv);
      cmps++;
      if (got !== expv) begin
         errs++;
         $display("FAIL %s: got %b required %b", name, got, expv);
      end
   endtask

   // output checker: every accepted row against the model, hold stability, done pulse
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check1("hold_valid", out_valid, 1'b1);
            checkv("hold_data", out_vec, prev_vec);
         end
         if (out_valid && out_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
               cmps++;
               errs++;
               $display("FAIL unexpected_row: got %h required no transfer", out_vec);
            end else begin
               cmp_e = exp_q.pop_front();
               checkv("row_data", out_vec, cmp_e);
               check1("done_pulse", done, exp_q.size() == 0);
               got_log.push_back(out_vec);
               if (exp_q.size() == 0) drains++;
            end
         end else begin
            check1("done_quiet", done, 1'b0);
         end
         prev_hold = out_valid && !out_ready;
         prev_vec  = out_vec;
      end
   end

   // advance one cycle, driving the array skew: lane c carries the row issued c cycles ago
   task automatic step(input bit iss, input bit f, input bit l, input vec_t row);
      @(posedge clk);
      #1;
      for (int i = NC - 1; i > 0; i--) begin
         hist_v[i] = hist_v[i-1];
         hist_d[i] = hist_d[i-1];
      end
      hist_v[0] = iss;
      hist_d[0] = row;
      for (int c = 0; c < NC; c++) begin
         in_psum_vec[c*W +: W] = hist_v[c] ? hist_d[c][c*W +: W] : W'($urandom);
      end
      in_valid      = iss;
      in_tile_first = iss ? f : 1'($urandom);
      in_tile_last  = iss ? l : 1'($urandom);
      case (ready_mode)
         1: begin out_ready = (pat % 3 == 0); pat++; end
         2: out_ready = 1'($urandom);
         3: out_ready = (xfers == xfer_base);
         default: out_ready = 1'b1;
      endcase
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, '0);
   endtask

   function automatic vec_t make_row(input int kind, input int m, input int v0, input int v1);
      vec_t r;
      for (int c = 0; c < NC; c++) begin
         case (kind)
            0:       r[c*W +: W] = W'(100 * m + c);
            1:       r[c*W +: W] = (m == 0) ? v0 : v1;
            default: r[c*W +: W] = $urandom;
         endcase
      end
      return r;
   endfunction

   // tile-level model: overwrite or saturating add per lane
   task automatic model_apply(input int m, input vec_t row, input bit first);
      int     v;
      longint s;
      for (int c = 0; c < NC; c++) begin
         v = row[c*W +: W];
         if (first) begin
            mbuf[m][c] = v;
         end else begin
            s = longint'(mbuf[m][c]) + longint'(v);
            if (s > 64'sd2147483647) begin
               s = 64'sd2147483647;
               model_ovf = 1'b1;
            end else if (s < -64'sd2147483648) begin
               s = -64'sd2147483648;
               model_ovf = 1'b1;
            end
            mbuf[m][c] = int'(s);
         end
      end
   endtask

   task automatic run_pass(input int rows, input bit first, input bit last, input int kind,
                           input int v0, input int v1, input bit gaps);
      vec_t r;
      vec_t e;
      for (int m = 0; m < rows; m++) begin
         if (gaps) repeat ($urandom_range(0, 2)) idle();
         r = make_row(kind, m, v0, v1);
         step(1'b1, first, last, r);
         model_apply(m, r, first);
      end
      if (last) begin
         for (int m = 0; m < rows; m++) begin
            for (int c = 0; c < NC; c++) e[c*W +: W] = mbuf[m][c];
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic wait_drain(input int budget);
      int start;
      int n;
      start = drains;
      n = 0;
      while (drains == start && n < budget) begin
         idle();
         n++;
      end
      if (drains == start) begin
         cmps++;
         errs++;
         $display("FAIL drain_timeout: got no completed drain in %0d cycles, required one", budget);
      end
   endtask

   task automatic pin(input string name, input int idx, input int lane, input logic [31:0] expv);
      vec_t g;
      if (idx >= got_log.size()) begin
         cmps++;
         errs++;
         $display("FAIL %s: got only %0d rows, required row %0d", name, got_log.size(), idx);
      end else begin
         g = got_log[idx];
         check32(name, g[lane*W +: W], expv);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t r0;
      int   rows;
      int   tiles;
      int   n;
      rst = 1'b1;
      in_psum_vec = '0;
      in_valid = 1'b0;
      in_tile_first = 1'b0;
      in_tile_last = 1'b0;
      out_ready = 1'b1;
      cfg_rows = 7'd4;
      for (int i = 0; i < NC; i++) begin hist_v[i] = 1'b0; hist_d[i] = '0; end

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check1("rst_in_ready", in_ready, 1'b1);
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_done", done, 1'b0);
      check1("rst_err_ovf", err_ovf, 1'b0);
      check1("rst_err_overrun", err_overrun, 1'b0);
      rst = 1'b0;
      repeat (2) idle();

      // deskew pass with latency checks
      got_log.delete();
      cfg_rows = 7'd4;
      run_pass(4, 1'b1, 1'b1, 0, 0, 0, 1'b0);
      repeat (15) idle();
      check1("lat_in_ready_accum", in_ready, 1'b1);
      idle();
      check1("lat_in_ready_drain", in_ready, 1'b0);
      check1("lat_out_valid_early", out_valid, 1'b0);
      idle();
      check1("lat_out_valid_rise", out_valid, 1'b1);
      r0 = make_row(0, 0, 0, 0);
      checkv("lat_row0", out_vec, r0);
      wait_drain(300);
      check32("deskew_rows", got_log.size(), 4);
      pin("deskew_r1l2", 1, 2, 32'd102);
      pin("deskew_r3l15", 3, 15, 32'd315);
      idle();
      check1("deskew_in_ready_back", in_ready, 1'b1);
      check1("deskew_err_ovf", err_ovf, 1'b0);

      // two-tile accumulate 5 + (-7)
      got_log.delete();
      cfg_rows = 7'd2;
      run_pass(2, 1'b1, 1'b0, 1, 5, 5, 1'b0);
      run_pass(2, 1'b0, 1'b1, 1, -7, -7, 1'b0);
      wait_drain(300);
      pin("accum_r0", 0, 0, 32'hFFFF_FFFE);
      pin("accum_r1", 1, 9, 32'hFFFF_FFFE);
      check1("accum_err_ovf", err_ovf, 1'b0);

      // saturation both directions
      got_log.delete();
      run_pass(2, 1'b1, 1'b0, 1, 32'h7FFF_FFF0, 32'h8000_0010, 1'b0);
      run_pass(2, 1'b0, 1'b1, 1, 32'h0000_0020, -32'sh20, 1'b0);
      wait_drain(300);
      pin("sat_pos", 0, 4, 32'h7FFF_FFFF);
      pin("sat_neg", 1, 11, 32'h8000_0000);
      check1("sat_err_ovf", err_ovf, 1'b1);

      // randomized multi-tile passes under 1,0,0 backpressure
      ready_mode = 1;
      for (int it = 0; it < 3; it++) begin
         rows = $urandom_range(3, 8);
         tiles = $urandom_range(1, 3);
         cfg_rows = 7'(rows);
         for (int t = 0; t < tiles; t++) begin
            run_pass(rows, t == 0, t == tiles - 1, 2, 0, 0, 1'b1);
         end
         repeat (16) idle();
         cfg_rows = 7'($urandom);
         wait_drain(400);
         check1("rand_err_ovf", err_ovf, model_ovf);
      end

      // overrun during drain
      cfg_rows = 7'd4;
      run_pass(4, 1'b1, 1'b1, 2, 0, 0, 1'b0);
      repeat (16) idle();
      check1("ovr_in_ready_low", in_ready, 1'b0);
      step(1'b1, 1'b1, 1'b1, make_row(2, 0, 0, 0));
      step(1'b1, 1'b0, 1'b1, make_row(2, 0, 0, 0));
      wait_drain(400);
      check1("ovr_err_overrun", err_overrun, 1'b1);
      idle();
      check1("ovr_in_ready_back", in_ready, 1'b1);

      // reset after the first of four drain transfers
      ready_mode = 3;
      xfer_base = xfers;
      run_pass(4, 1'b1, 1'b1, 2, 0, 0, 1'b0);
      n = 0;
      while (xfers == xfer_base && n < 200) begin
         idle();
         n++;
      end
      check32("rstmid_one_xfer", xfers - xfer_base, 1);
      rst = 1'b1;
      #1;
      check1("rstmid_out_valid", out_valid, 1'b0);
      check1("rstmid_in_ready", in_ready, 1'b1);
      check1("rstmid_err_overrun", err_overrun, 1'b0);
      exp_q.delete();
      model_ovf = 1'b0;
      ready_mode = 0;
      repeat (2) idle();
      rst = 1'b0;
      idle();
      got_log.delete();
      cfg_rows = 7'd1;
      run_pass(1, 1'b1, 1'b1, 2, 0, 0, 1'b0);
      wait_drain(300);
      check32("rstmid_rows_after", got_log.size(), 1);
      check1("rstmid_err_ovf", err_ovf, 1'b0);
      repeat (3) idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
